l0_array_seq_ctrl: RTL and testbench

//  Parametrised L0->PE-array sequencer: per kernel position (kij) loads ROW weight vectors, waits a drain gap,

---
 rtl/l0_seq_pkg.sv | 17 +
 rtl/l0_seq_dly_pipe.sv | 26 ++
 rtl/l0_array_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_l0_array_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l0_seq_pkg.sv
// Shared state encoding and PE-array instruction codes for the L0 -> PE-array sequencer.
package l0_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WLOAD   = 3'd1,
    DRAIN   = 3'd2,
    XSTREAM = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [1:0] INST_NOP   = 2'b00;
  localparam logic [1:0] INST_WLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/l0_seq_dly_pipe.sv
// Fixed-depth single-bit delay line; a synchronous clear flushes everything in flight.
module l0_seq_dly_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else begin
      sr <= DEPTH'({sr, d});
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/l0_array_seq_ctrl.sv
// L0 -> PE-array sequencer: per kij loads ROW weights, drains, streams activations, then reports done.
// Optional stall counter output enabled with `define L0SEQ_PERF_CNT_EN.
module l0_array_seq_ctrl
  import l0_seq_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int MAX_ONIJ  = 64,
  parameter int MAX_KIJ   = 9,
  parameter int DRAIN_CYC = 4,
  parameter int RD_EN_DLY = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [$clog2(MAX_ONIJ+1)-1:0] cfg_len_onij_i,
  input  logic [$clog2(MAX_KIJ+1)-1:0]  cfg_num_kij_i,
  input  logic                          corelet_l0_rd_ready_i,
  output logic [1:0]                    inst_o,
  output logic                          corelet_l0_rd_en_o,
  output logic                          corelet_weight_overwrite_o,
  output logic [$clog2(MAX_KIJ+1)-1:0]  kij_idx_o,
  output logic                          busy_o,
  output logic                          done_o
`ifdef L0SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                   perf_stall_cnt_o
`endif
);

  localparam int LEN_W  = $clog2(MAX_ONIJ + 1);
  localparam int KIJ_W  = $clog2(MAX_KIJ + 1);
  localparam int WCNT_W = $clog2(ROW + 1);
  localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

  localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_ONIJ);
  localparam logic [KIJ_W-1:0]  KIJ_MAX    = KIJ_W'(MAX_KIJ);
  localparam logic [WCNT_W-1:0] ROW_C      = WCNT_W'(ROW);
  localparam logic [WCNT_W-1:0] ROW_LAST   = WCNT_W'(ROW - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

  state_e             state;
  logic [LEN_W-1:0]   len_q;
  logic [KIJ_W-1:0]   num_kij_q;
  logic [WCNT_W-1:0]  wcnt;
  logic [LEN_W-1:0]   xcnt;
  logic [DCNT_W-1:0]  dcnt;

  logic [LEN_W-1:0]   len_sat;
  logic [KIJ_W-1:0]   kij_sat;
  logic               w_issue;
  logic               x_issue;
  logic               issue;

  assign len_sat = (cfg_len_onij_i > LEN_MAX) ? LEN_MAX : cfg_len_onij_i;
  assign kij_sat = (cfg_num_kij_i > KIJ_MAX) ? KIJ_MAX : cfg_num_kij_i;

  // A stalled cycle (rd_ready low) simply does not issue; the counters hold.
  assign w_issue = (state == WLOAD)   && corelet_l0_rd_ready_i && (wcnt < ROW_C);
  assign x_issue = (state == XSTREAM) && corelet_l0_rd_ready_i && (xcnt < len_q);
  assign issue   = w_issue || x_issue;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= IDLE;
      len_q                      <= '0;
      num_kij_q                  <= '0;
      wcnt                       <= '0;
      xcnt                       <= '0;
      dcnt                       <= '0;
      kij_idx_o                  <= '0;
      inst_o                     <= INST_NOP;
      corelet_weight_overwrite_o <= 1'b0;
      busy_o                     <= 1'b0;
      done_o                     <= 1'b0;
    end else if (abort_i) begin
      state                      <= IDLE;
      wcnt                       <= '0;
      xcnt                       <= '0;
      dcnt                       <= '0;
      kij_idx_o                  <= '0;
      inst_o                     <= INST_NOP;
      corelet_weight_overwrite_o <= 1'b0;
      busy_o                     <= 1'b0;
      done_o                     <= 1'b0;
    end else begin
      inst_o                     <= w_issue ? INST_WLOAD : (x_issue ? INST_EXEC : INST_NOP);
      corelet_weight_overwrite_o <= 1'b0;
      done_o                     <= 1'b0;
      if (w_issue) wcnt <= wcnt + WCNT_W'(1);
      if (x_issue) xcnt <= xcnt + LEN_W'(1);

      case (state)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_sat;
            num_kij_q <= kij_sat;
            wcnt      <= '0;
            xcnt      <= '0;
            dcnt      <= '0;
            kij_idx_o <= '0;
            busy_o    <= 1'b1;
            state     <= (kij_sat == '0) ? DONE : WLOAD;
          end
        end
        WLOAD: begin
          if (w_issue && (wcnt == ROW_LAST)) state <= DRAIN;
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            dcnt  <= '0;
            state <= (len_q == '0) ? NEXT : XSTREAM;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        XSTREAM: begin
          if (x_issue && (xcnt == len_q - LEN_W'(1))) state <= NEXT;
        end
        NEXT: begin
          if (kij_idx_o + KIJ_W'(1) == num_kij_q) begin
            state <= DONE;
          end else begin
            kij_idx_o                  <= kij_idx_o + KIJ_W'(1);
            corelet_weight_overwrite_o <= 1'b1;
            wcnt                       <= '0;
            xcnt                       <= '0;
            state                      <= WLOAD;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  l0_seq_dly_pipe #(
    .DEPTH (RD_EN_DLY)
  ) u_rd_en_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (abort_i),
    .d       (issue),
    .q       (corelet_l0_rd_en_o)
  );

`ifdef L0SEQ_PERF_CNT_EN
  // Stall cycles are those spent in an issue state while L0 has nothing to give.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt_o <= '0;
    end else if ((state == IDLE) && start_i && !abort_i) begin
      perf_stall_cnt_o <= '0;
    end else if (((state == WLOAD) || (state == XSTREAM)) && !corelet_l0_rd_ready_i &&
                 (perf_stall_cnt_o != 16'hFFFF)) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l0_array_seq_ctrl.sv
// Directed bench for l0_array_seq_ctrl: issue counts, alignment, drain gap, corner configs, abort, reset.
module tb_l0_array_seq_ctrl;
  import l0_seq_pkg::*;

  localparam int ROW       = 8;
  localparam int MAX_ONIJ  = 64;
  localparam int MAX_KIJ   = 9;
  localparam int DRAIN_CYC = 4;
  localparam int RD_EN_DLY = 2;
  localparam int LEN_W     = $clog2(MAX_ONIJ + 1);
  localparam int KIJ_W     = $clog2(MAX_KIJ + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             rd_ready = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [KIJ_W-1:0] cfg_kij = '0;
  logic [1:0]       inst;
  logic             rd_en;
  logic             ow;
  logic [KIJ_W-1:0] kij_idx;
  logic             busy;
  logic             done;
`ifdef L0SEQ_PERF_CNT_EN
  logic [15:0]      perf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l0_array_seq_ctrl #(
    .ROW       (ROW),
    .MAX_ONIJ  (MAX_ONIJ),
    .MAX_KIJ   (MAX_KIJ),
    .DRAIN_CYC (DRAIN_CYC),
    .RD_EN_DLY (RD_EN_DLY)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .start_i                    (start_i),
    .abort_i                    (abort_i),
    .cfg_len_onij_i             (cfg_len),
    .cfg_num_kij_i              (cfg_kij),
    .corelet_l0_rd_ready_i      (rd_ready),
    .inst_o                     (inst),
    .corelet_l0_rd_en_o         (rd_en),
    .corelet_weight_overwrite_o (ow),
    .kij_idx_o                  (kij_idx),
    .busy_o                     (busy),
    .done_o                     (done)
`ifdef L0SEQ_PERF_CNT_EN
    ,
    .perf_stall_cnt_o           (perf)
`endif
  );

  // Output monitor, sampled on the falling edge.
  typedef struct {
    int w; int x; int rd; int ow; int dn; int gap; int gap_bad; int align_bad;
  } snap_t;

  snap_t      mon;
  int         cyc = 0;
  int         last_w = 0;
  bit         prev_w = 1'b0;
  logic [8:0] ih = '0;
  logic [8:0] ih_now;

  initial mon = '{default: 0};

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      ih     = '0;
      prev_w = 1'b0;
    end else begin
      ih_now = {ih[7:0], inst != INST_NOP};
      if (rd_en !== ih_now[RD_EN_DLY-1]) mon.align_bad++;
      ih = ih_now;
      if (inst == INST_WLOAD) begin
        mon.w++;
        last_w = cyc;
        prev_w = 1'b1;
      end
      if (inst == INST_EXEC) begin
        mon.x++;
        if (prev_w) begin
          mon.gap++;
          if (cyc - last_w - 1 != DRAIN_CYC) mon.gap_bad++;
          prev_w = 1'b0;
        end
      end
      if (rd_en) mon.rd++;
      if (ow)    mon.ow++;
      if (done)  mon.dn++;
    end
  end

  function automatic snap_t diff(input snap_t a, input snap_t b);
    snap_t d;
    d.w = b.w - a.w;   d.x = b.x - a.x;     d.rd = b.rd - a.rd;   d.ow = b.ow - a.ow;
    d.dn = b.dn - a.dn; d.gap = b.gap - a.gap; d.gap_bad = b.gap_bad - a.gap_bad;
    d.align_bad = b.align_bad - a.align_bad;
    return d;
  endfunction

  task automatic do_start(input int len, input int kij, input logic rdy);
    @(negedge clk);
    cfg_len  = LEN_W'(len);
    cfg_kij  = KIJ_W'(kij);
    rd_ready = rdy;
    start_i  = 1'b1;
  endtask

  // mode 1 toggles rd_ready each cycle; noise pulses start_i with a different config while busy.
  task automatic run(input bit mode, input bit noise, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mode) rd_ready = ~rd_ready;
      if (done) begin
        seen    = 1'b1;
        start_i = 1'b0;
      end else if (noise) begin
        cfg_len = LEN_W'(5);
        cfg_kij = KIJ_W'(3);
        start_i = (i % 4 == 1);
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_counts(input string tag, input snap_t d, input bit seen,
                               input int ew, input int ex, input int erd, input int eow);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL %s_timeout done not seen", tag); end
    checks++;
    if (d.w !== ew) begin errors++; $display("FAIL %s_loads got %0d want %0d", tag, d.w, ew); end
    checks++;
    if (d.x !== ex) begin errors++; $display("FAIL %s_execs got %0d want %0d", tag, d.x, ex); end
    checks++;
    if (d.rd !== erd) begin errors++; $display("FAIL %s_rd_en got %0d want %0d", tag, d.rd, erd); end
    checks++;
    if (d.ow !== eow) begin errors++; $display("FAIL %s_overwrite got %0d want %0d", tag, d.ow, eow); end
    checks++;
    if (d.dn !== 1) begin errors++; $display("FAIL %s_done got %0d want 1", tag, d.dn); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({inst, rd_en, ow, kij_idx, busy, done} !== '0) begin
      errors++; $display("FAIL reset_during got %b want 0", {inst, rd_en, ow, kij_idx, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({inst, rd_en, ow, kij_idx, busy, done} !== '0) begin
      errors++; $display("FAIL reset_after got %b want 0", {inst, rd_en, ow, kij_idx, busy, done});
    end
  endtask

  task automatic test_full_ready();
    snap_t s0, d;
    bit    seen;
    s0 = mon;
    do_start(16, 9, 1'b1);
    run(1'b0, 1'b0, 2000, seen);
    d = diff(s0, mon);
    expect_counts("full", d, seen, 72, 144, 216, 8);
    checks++;
    if (d.gap !== 9 || d.gap_bad !== 0) begin
      errors++; $display("FAIL full_drain_gap gaps %0d bad %0d want 9 and 0", d.gap, d.gap_bad);
    end
    checks++;
    if (d.align_bad !== 0) begin errors++; $display("FAIL full_align got %0d want 0", d.align_bad); end
  endtask

  task automatic test_toggle_ready();
    snap_t s0, d;
    bit    seen;
    s0 = mon;
    do_start(16, 9, 1'b0);
    run(1'b1, 1'b0, 2000, seen);
    d = diff(s0, mon);
    expect_counts("toggle", d, seen, 72, 144, 216, 8);
    checks++;
    if (d.align_bad !== 0) begin errors++; $display("FAIL toggle_align got %0d want 0", d.align_bad); end
`ifdef L0SEQ_PERF_CNT_EN
    checks++;
    if (perf !== 16'd207) begin errors++; $display("FAIL toggle_perf got %0d want 207", perf); end
`endif
    rd_ready = 1'b1;
  endtask

  task automatic test_zero_cfg();
    snap_t s0, d;
    bit    seen;
    s0 = mon;
    do_start(16, 0, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL kij0_cycle1 done %b busy %b want 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL kij0_cycle2 done %b busy %b want 1 0", done, busy);
    end
    repeat (3) @(negedge clk);
    d = diff(s0, mon);
    checks++;
    if (d.rd !== 0 || d.dn !== 1) begin
      errors++; $display("FAIL kij0_counts rd_en %0d done %0d want 0 1", d.rd, d.dn);
    end
    s0 = mon;
    do_start(0, 2, 1'b1);
    run(1'b0, 1'b0, 500, seen);
    d = diff(s0, mon);
    expect_counts("len0", d, seen, 16, 0, 16, 1);
  endtask

  task automatic test_saturate();
    snap_t s0, d;
    bit    seen;
    s0 = mon;
    do_start(127, 1, 1'b1);
    run(1'b0, 1'b0, 500, seen);
    d = diff(s0, mon);
    expect_counts("sat_len", d, seen, 8, 64, 72, 0);
    s0 = mon;
    do_start(0, 15, 1'b1);
    run(1'b0, 1'b0, 1000, seen);
    d = diff(s0, mon);
    expect_counts("sat_kij", d, seen, 72, 0, 72, 8);
  endtask

  task automatic test_abort();
    snap_t s0, d;
    bit    seen;
    bit    hit = 1'b0;
    do_start(16, 9, 1'b1);
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (kij_idx == KIJ_W'(3) && inst == INST_EXEC) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach kij3 exec not seen"); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if ({busy, inst, rd_en, kij_idx} !== '0) begin
      errors++; $display("FAIL abort_next got %b want 0", {busy, inst, rd_en, kij_idx});
    end
    s0 = mon;
    repeat (20) @(negedge clk);
    d = diff(s0, mon);
    checks++;
    if (d.rd !== 0 || d.dn !== 0 || d.w !== 0 || d.x !== 0) begin
      errors++; $display("FAIL abort_quiet rd %0d done %0d inst %0d want all 0", d.rd, d.dn, d.w + d.x);
    end
    s0 = mon;
    do_start(3, 2, 1'b1);
    run(1'b0, 1'b0, 500, seen);
    d = diff(s0, mon);
    expect_counts("restart", d, seen, 16, 6, 22, 1);
    checks++;
    if (d.align_bad !== 0) begin errors++; $display("FAIL restart_align got %0d want 0", d.align_bad); end
  endtask

  task automatic test_reset_mid_and_busy_start();
    snap_t s0, d;
    bit    seen;
    bit    hit = 1'b0;
    do_start(16, 9, 1'b1);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (inst == INST_WLOAD) hit = 1'b1;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({inst, rd_en, ow, kij_idx, busy, done} !== '0 || !hit) begin
      errors++; $display("FAIL reset_mid got %b hit %b want 0 1", {inst, rd_en, ow, kij_idx, busy, done}, hit);
    end
    @(negedge clk);
    reset_n = 1'b1;
    s0 = mon;
    repeat (5) @(negedge clk);
    d = diff(s0, mon);
    checks++;
    if (d.dn !== 0 || d.rd !== 0) begin
      errors++; $display("FAIL reset_mid_quiet done %0d rd %0d want 0 0", d.dn, d.rd);
    end
    s0 = mon;
    do_start(2, 1, 1'b1);
    run(1'b0, 1'b1, 500, seen);
    d = diff(s0, mon);
    expect_counts("busy_start", d, seen, 8, 2, 10, 0);
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_toggle_ready();
    test_zero_cfg();
    test_saturate();
    test_abort();
    test_reset_mid_and_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
